// File: rtl/mss_bus_switch_pkg.sv
// Shared definitions for the MSS bus switch blocks.
//   head_st_t   : default-slave head-of-queue FSM state
//   cmd_ent_t   : command queue entry {excl, read, burst_size}
//   BSZ_W       : IBP burst-size field width
//   RESP_*      : response encoding (OKAY vs error)
package mss_bus_switch_pkg;

    localparam int BSZ_W = 4;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERR   = 1'b1;
    // Exclusive accesses are recorded but the default slave never grants them.
    localparam logic EXCL_GRANT = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WRSP
    } head_st_t;

    typedef struct packed {
        logic             excl;
        logic             read;
        logic [BSZ_W-1:0] bsz;
    } cmd_ent_t;

endpackage

// File: rtl/mss_bus_switch_cmd_fifo.sv
// Generic W x DEPTH circular FIFO with full/empty flags.
//   clk, rst_a   : clock, async active-low reset
//   push, wdata  : write side (ignored when full)
//   pop, rdata   : read side, rdata is the current head (ignored when empty)
//   full, empty  : occupancy flags from registered pointers
module mss_bus_switch_cmd_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_a,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PW:0]  wptr, rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[PW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

endmodule

// File: rtl/mss_bus_switch_default_slv_q.sv
// IBP default slave for unmapped space in the MSS bus switch.
// Queues up to OUTSTD commands and answers them strictly in order: reads
// return burst_size+1 beats of RD_PAT, writes sink beats up to wr_last then
// return one response. Diagnostics capture the first offending address and
// count terminated commands (saturating).
//   clk, rst_a              : clock, async active-low reset
//   def_slv_ibp_cmd_*       : command channel
//   def_slv_ibp_rd_*/err_rd : read data channel
//   def_slv_ibp_wr_*/err_wr : write data and write response channels
//   diag_*                  : address capture and command counter
module mss_bus_switch_default_slv_q
    import mss_bus_switch_pkg::*;
#(
    parameter int            AW     = 32,
    parameter int            DW     = 64,
    parameter int            OUTSTD = 4,
    parameter bit            RD_ERR = 1'b1,
    parameter bit            WR_ERR = 1'b1,
    parameter logic [DW-1:0] RD_PAT = '0,
    parameter int            CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             def_slv_ibp_cmd_valid,
    output logic             def_slv_ibp_cmd_accept,
    input  logic             def_slv_ibp_cmd_read,
    input  logic [AW-1:0]    def_slv_ibp_cmd_addr,
    input  logic [3:0]       def_slv_ibp_cmd_burst_size,
    input  logic             def_slv_ibp_cmd_excl,
    output logic             def_slv_ibp_rd_valid,
    output logic             def_slv_ibp_err_rd,
    input  logic             def_slv_ibp_rd_accept,
    output logic [DW-1:0]    def_slv_ibp_rd_data,
    output logic             def_slv_ibp_rd_last,
    output logic             def_slv_ibp_rd_excl_ok,
    input  logic             def_slv_ibp_wr_valid,
    output logic             def_slv_ibp_wr_accept,
    input  logic             def_slv_ibp_wr_last,
    output logic             def_slv_ibp_wr_done,
    output logic             def_slv_ibp_err_wr,
    output logic             def_slv_ibp_wr_excl_done,
    input  logic             def_slv_ibp_wr_resp_accept,
    input  logic             diag_err_clr,
    output logic             diag_err_vld,
    output logic [AW-1:0]    diag_err_addr,
    output logic             diag_err_read,
    output logic [CNT_W-1:0] diag_cmd_cnt
);

    localparam logic RD_RESP = RD_ERR ? RESP_ERR : RESP_OKAY;
    localparam logic WR_RESP = WR_ERR ? RESP_ERR : RESP_OKAY;

    head_st_t         state, nxt;
    cmd_ent_t         push_ent, head;
    logic             full, empty, push, pop;
    logic [BSZ_W-1:0] beat_cnt;
    logic             beat_vld, last_beat, resp_vld;

    // Gating with rst_a keeps every output low while reset is held.
    assign def_slv_ibp_cmd_accept = ~full & rst_a;
    assign push = def_slv_ibp_cmd_valid & def_slv_ibp_cmd_accept;

    assign push_ent = '{excl: def_slv_ibp_cmd_excl,
                        read: def_slv_ibp_cmd_read,
                        bsz:  def_slv_ibp_cmd_burst_size};

    mss_bus_switch_cmd_fifo #(.W($bits(cmd_ent_t)), .DEPTH(OUTSTD)) u_cmd_fifo (
        .clk   (clk),
        .rst_a (rst_a),
        .push  (push),
        .wdata (push_ent),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign beat_vld  = (state == ST_RD);
    assign last_beat = beat_vld & (beat_cnt == head.bsz);
    assign resp_vld  = (state == ST_WRSP);

    assign pop = (last_beat & def_slv_ibp_rd_accept)
               | (resp_vld & def_slv_ibp_wr_resp_accept);

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) state <= ST_IDLE;
        else        state <= nxt;
    end

    // From IDLE with an empty queue the incoming push is dispatched directly,
    // so the first beat appears the cycle after the command handshake.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (!empty)    nxt = head.read ? ST_RD : ST_WR;
                else if (push) nxt = def_slv_ibp_cmd_read ? ST_RD : ST_WR;
            end
            ST_RD:   if (last_beat & def_slv_ibp_rd_accept) nxt = ST_IDLE;
            ST_WR:   if (def_slv_ibp_wr_valid & def_slv_ibp_wr_last) nxt = ST_WRSP;
            ST_WRSP: if (def_slv_ibp_wr_resp_accept) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a)
            beat_cnt <= '0;
        else if (beat_vld & def_slv_ibp_rd_accept)
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end

    assign def_slv_ibp_rd_valid     = beat_vld & (RD_RESP == RESP_OKAY);
    assign def_slv_ibp_err_rd       = beat_vld & (RD_RESP == RESP_ERR);
    assign def_slv_ibp_rd_last      = last_beat;
    assign def_slv_ibp_rd_data      = RD_PAT;
    assign def_slv_ibp_rd_excl_ok   = beat_vld & head.excl & EXCL_GRANT;
    assign def_slv_ibp_wr_accept    = (state == ST_WR) & def_slv_ibp_wr_valid;
    assign def_slv_ibp_wr_done      = resp_vld & (WR_RESP == RESP_OKAY);
    assign def_slv_ibp_err_wr       = resp_vld & (WR_RESP == RESP_ERR);
    assign def_slv_ibp_wr_excl_done = resp_vld & head.excl & EXCL_GRANT;

    // A clear coinciding with a push re-arms and captures the new command.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            diag_err_vld  <= 1'b0;
            diag_err_addr <= '0;
            diag_err_read <= 1'b0;
        end else if (push && (!diag_err_vld || diag_err_clr)) begin
            diag_err_vld  <= 1'b1;
            diag_err_addr <= def_slv_ibp_cmd_addr;
            diag_err_read <= def_slv_ibp_cmd_read;
        end else if (diag_err_clr) begin
            diag_err_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a)
            diag_cmd_cnt <= '0;
        else if (push && (diag_cmd_cnt != {CNT_W{1'b1}}))
            diag_cmd_cnt <= diag_cmd_cnt + 1'b1;
    end

endmodule

// File: tb/tb_mss_bus_switch_default_slv_q.sv
module tb_mss_bus_switch_default_slv_q;

    localparam int            AW     = 32;
    localparam int            DW     = 64;
    localparam int            OUTSTD = 4;
    localparam int            CNT_W  = 2;
    localparam logic [DW-1:0] PAT    = 64'hA5A5_0F0F_DEAD_BEEF;

    logic             clk = 1'b0;
    logic             rst_a = 1'b1;
    logic             cmd_valid = 0, cmd_read = 0, cmd_excl = 0;
    logic [AW-1:0]    cmd_addr = '0;
    logic [3:0]       cmd_bsz = '0;
    logic             rd_accept = 0, wr_valid = 0, wr_last = 0, wr_resp_accept = 0;
    logic             diag_err_clr = 0;
    logic             cmd_accept, rd_valid, err_rd, rd_last, rd_excl_ok;
    logic [DW-1:0]    rd_data;
    logic             wr_accept, wr_done, err_wr, wr_excl_done;
    logic             diag_err_vld, diag_err_read;
    logic [AW-1:0]    diag_err_addr;
    logic [CNT_W-1:0] diag_cmd_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mss_bus_switch_default_slv_q #(
        .AW(AW), .DW(DW), .OUTSTD(OUTSTD), .RD_ERR(1'b1), .WR_ERR(1'b1),
        .RD_PAT(PAT), .CNT_W(CNT_W)
    ) dut (
        .clk                        (clk),
        .rst_a                      (rst_a),
        .def_slv_ibp_cmd_valid      (cmd_valid),
        .def_slv_ibp_cmd_accept     (cmd_accept),
        .def_slv_ibp_cmd_read       (cmd_read),
        .def_slv_ibp_cmd_addr       (cmd_addr),
        .def_slv_ibp_cmd_burst_size (cmd_bsz),
        .def_slv_ibp_cmd_excl       (cmd_excl),
        .def_slv_ibp_rd_valid       (rd_valid),
        .def_slv_ibp_err_rd         (err_rd),
        .def_slv_ibp_rd_accept      (rd_accept),
        .def_slv_ibp_rd_data        (rd_data),
        .def_slv_ibp_rd_last        (rd_last),
        .def_slv_ibp_rd_excl_ok     (rd_excl_ok),
        .def_slv_ibp_wr_valid       (wr_valid),
        .def_slv_ibp_wr_accept      (wr_accept),
        .def_slv_ibp_wr_last        (wr_last),
        .def_slv_ibp_wr_done        (wr_done),
        .def_slv_ibp_err_wr         (err_wr),
        .def_slv_ibp_wr_excl_done   (wr_excl_done),
        .def_slv_ibp_wr_resp_accept (wr_resp_accept),
        .diag_err_clr               (diag_err_clr),
        .diag_err_vld               (diag_err_vld),
        .diag_err_addr              (diag_err_addr),
        .diag_err_read              (diag_err_read),
        .diag_cmd_cnt               (diag_cmd_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set afterwards
    // apply to the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_acc"},  cmd_accept, 0);
        chk({tag, "_rdv"},  rd_valid, 0);
        chk({tag, "_erd"},  err_rd, 0);
        chk({tag, "_last"}, rd_last, 0);
        chk({tag, "_rex"},  rd_excl_ok, 0);
        chk({tag, "_wacc"}, wr_accept, 0);
        chk({tag, "_wdn"},  wr_done, 0);
        chk({tag, "_ewr"},  err_wr, 0);
        chk({tag, "_wex"},  wr_excl_done, 0);
        chk({tag, "_dvld"}, diag_err_vld, 0);
        chk({tag, "_dadr"}, diag_err_addr, 0);
        chk({tag, "_drd"},  diag_err_read, 0);
        chk({tag, "_dcnt"}, diag_cmd_cnt, 0);
        chk({tag, "_data"}, rd_data, PAT);
    endtask

    task automatic push_cmd(input logic rd, input logic [3:0] bsz, input logic [AW-1:0] a);
        cmd_valid = 1; cmd_read = rd; cmd_bsz = bsz; cmd_addr = a;
    endtask

    typedef struct { bit read; int bsz; } mcmd_t;

    initial begin
        mcmd_t q[$];
        int    beats, npush, cyc;
        bit    wlast_seen, m_vld, m_rd, ok, do_pop, do_push;
        logic [AW-1:0] m_addr;
        int    m_cnt;
        int    n_rand = 40;

        // ---------------- reset
        #1 rst_a = 0;
        tick(); tick();
        settle();
        chk_all_zero("rst");
        rst_a = 1;
        settle();
        chk("rst_rel_acc", cmd_accept, 1);

        // ---------------- read burst of 4, error response
        tick();
        push_cmd(1, 4'd3, 32'h100); rd_accept = 1;
        settle();
        chk("t1_acc", cmd_accept, 1);
        chk("t1_erd_pre", err_rd, 0);
        tick();
        cmd_valid = 0;
        for (int b = 0; b < 4; b++) begin
            settle();
            chk("t1_erd", err_rd, 1);
            chk("t1_rdv", rd_valid, 0);
            chk("t1_last", rd_last, (b == 3));
            chk("t1_data", rd_data, PAT);
            tick();
        end
        settle();
        chk("t1_erd_end", err_rd, 0);
        chk("t1_dvld", diag_err_vld, 1);
        chk("t1_dadr", diag_err_addr, 32'h100);
        chk("t1_drd", diag_err_read, 1);
        chk("t1_dcnt", diag_cmd_cnt, 1);

        // ---------------- write burst of 2, slow response accept
        tick();
        push_cmd(0, 4'd1, 32'h200); rd_accept = 0;
        tick();
        cmd_valid = 0; wr_valid = 1; wr_last = 0;
        settle();
        chk("t2_wacc0", wr_accept, 1);
        chk("t2_ewr0", err_wr, 0);
        tick();
        wr_last = 1;
        settle();
        chk("t2_wacc1", wr_accept, 1);
        tick();
        wr_valid = 0; wr_last = 0; wr_resp_accept = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t2_ewr_hold", err_wr, 1);
            chk("t2_wdn", wr_done, 0);
            tick();
        end
        wr_resp_accept = 1;
        settle();
        chk("t2_ewr_acc", err_wr, 1);
        tick();
        wr_resp_accept = 0;
        settle();
        chk("t2_ewr_drop", err_wr, 0);
        chk("t2_dadr", diag_err_addr, 32'h100);
        chk("t2_dcnt", diag_cmd_cnt, 2);

        // ---------------- fill the queue behind a stalled read
        tick();
        rd_accept = 0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(1, 4'd0, 32'h1000 + i);
            settle();
            chk("t3_acc_fill", cmd_accept, 1);
            tick();
        end
        push_cmd(1, 4'd0, 32'h1004);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t3_acc_full", cmd_accept, 0);
            chk("t3_erd_stall", err_rd, 1);
            tick();
        end
        rd_accept = 1;
        settle();
        chk("t3_last", rd_last, 1);
        chk("t3_acc_pop", cmd_accept, 0);
        tick();
        rd_accept = 0;
        settle();
        chk("t3_acc_free", cmd_accept, 1);
        chk("t3_gap", err_rd, 0);
        tick();
        cmd_valid = 0;
        settle();
        chk("t3_acc_refull", cmd_accept, 0);
        rd_accept = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t3_drain_erd", err_rd, 1);
            chk("t3_drain_last", rd_last, 1);
            tick();
            settle();
            chk("t3_drain_gap", err_rd, 0);
            if (k < 3) tick();
        end
        chk("t3_dcnt_sat", diag_cmd_cnt, 3);
        chk("t3_acc_empty", cmd_accept, 1);

        // ---------------- interleaved read / write / read
        tick();
        rd_accept = 0; wr_valid = 1; wr_last = 1;
        push_cmd(1, 4'd0, 32'h2000);
        settle();
        chk("t4_wacc_idle", wr_accept, 0);
        tick();
        push_cmd(0, 4'd0, 32'h2004);
        settle();
        chk("t4_wacc_rd0", wr_accept, 0);
        chk("t4_erd0", err_rd, 1);
        tick();
        push_cmd(1, 4'd2, 32'h2008);
        settle();
        chk("t4_wacc_rd1", wr_accept, 0);
        tick();
        cmd_valid = 0;
        rd_accept = 1;
        settle();
        chk("t4_wacc_rd2", wr_accept, 0);
        chk("t4_last0", rd_last, 1);
        chk("t4_ewr0", err_wr, 0);
        tick();
        rd_accept = 0;
        settle();
        chk("t4_wacc_gap", wr_accept, 0);
        chk("t4_erd_gap", err_rd, 0);
        tick();
        settle();
        chk("t4_wacc_wr", wr_accept, 1);
        chk("t4_erd_wr", err_rd, 0);
        tick();
        wr_valid = 0; wr_last = 0; wr_resp_accept = 1;
        settle();
        chk("t4_ewr", err_wr, 1);
        chk("t4_erd_rsp", err_rd, 0);
        tick();
        wr_resp_accept = 0;
        settle();
        chk("t4_ewr_drop", err_wr, 0);
        tick();
        rd_accept = 1;
        for (int b = 0; b < 3; b++) begin
            settle();
            chk("t4_erd2", err_rd, 1);
            chk("t4_last2", rd_last, (b == 2));
            tick();
        end
        settle();
        chk("t4_idle", err_rd, 0);

        // ---------------- diagnostic clear
        chk("t5_dadr_pre", diag_err_addr, 32'h100);
        diag_err_clr = 1;
        push_cmd(1, 4'd0, 32'h300);
        tick();
        diag_err_clr = 0; cmd_valid = 0;
        settle();
        chk("t5_dvld", diag_err_vld, 1);
        chk("t5_dadr", diag_err_addr, 32'h300);
        tick();
        diag_err_clr = 1;
        tick();
        diag_err_clr = 0;
        settle();
        chk("t5_dvld_clr", diag_err_vld, 0);
        push_cmd(0, 4'd0, 32'h400);
        tick();
        cmd_valid = 0;
        settle();
        chk("t5_dvld2", diag_err_vld, 1);
        chk("t5_dadr2", diag_err_addr, 32'h400);
        chk("t5_drd2", diag_err_read, 0);
        wr_valid = 1; wr_last = 1;
        tick();
        wr_valid = 0; wr_last = 0; wr_resp_accept = 1;
        settle();
        chk("t5_ewr", err_wr, 1);
        tick();
        wr_resp_accept = 0;

        // ---------------- reset in the middle of a read burst
        push_cmd(1, 4'd3, 32'h500); rd_accept = 1;
        tick();
        cmd_valid = 0;
        tick(); tick();
        settle();
        chk("t6_erd_b2", err_rd, 1);
        chk("t6_last_b2", rd_last, 0);
        rst_a = 0;
        #1;
        chk_all_zero("t6_rst");
        tick();
        rst_a = 1;
        settle();
        chk("t6_acc", cmd_accept, 1);
        chk("t6_erd", err_rd, 0);
        push_cmd(1, 4'd3, 32'h600);
        tick();
        cmd_valid = 0;
        for (int b = 0; b < 4; b++) begin
            settle();
            chk("t6_erd_fresh", err_rd, 1);
            chk("t6_last_fresh", rd_last, (b == 3));
            tick();
        end
        settle();
        chk("t6_erd_end", err_rd, 0);
        chk("t6_dadr", diag_err_addr, 32'h600);

        // ---------------- randomized traffic against a transaction model
        rst_a = 0;
        tick();
        rst_a = 1;
        q.delete();
        beats = 0; npush = 0; cyc = 0; wlast_seen = 0;
        m_vld = 0; m_rd = 0; m_addr = '0; m_cnt = 0;
        while (npush < n_rand || q.size() != 0) begin
            if (cyc >= 3000) begin
                chk("rnd_timeout", 1'b0, 1'b1);
                break;
            end
            cyc++;
            cmd_valid      = (npush < n_rand) && ($urandom_range(0, 2) != 0);
            cmd_read       = 1'($urandom_range(0, 1));
            cmd_bsz        = 4'($urandom_range(0, 3));
            cmd_addr       = $urandom;
            rd_accept      = ($urandom_range(0, 3) != 0);
            wr_valid       = ($urandom_range(0, 2) != 0);
            wr_last        = 1'($urandom_range(0, 1));
            wr_resp_accept = 1'($urandom_range(0, 1));
            diag_err_clr   = ($urandom_range(0, 15) == 0);
            settle();

            chk("rnd_acc", cmd_accept, (q.size() < OUTSTD));
            chk("rnd_rdv", rd_valid, 0);
            chk("rnd_wdn", wr_done, 0);
            chk("rnd_data", rd_data, PAT);
            if (err_rd) begin
                ok = (q.size() > 0) && q[0].read;
                chk("rnd_rd_head", ok, 1);
                if (ok) chk("rnd_rd_last", rd_last, (beats == q[0].bsz));
            end else begin
                chk("rnd_last_idle", rd_last, 0);
            end
            if (wr_accept) chk("rnd_wr_head", (q.size() > 0) && !q[0].read && !wlast_seen, 1);
            if (err_wr)    chk("rnd_wr_resp", (q.size() > 0) && !q[0].read && wlast_seen, 1);
            chk("rnd_dvld", diag_err_vld, m_vld);
            if (m_vld) begin
                chk("rnd_dadr", diag_err_addr, m_addr);
                chk("rnd_drd", diag_err_read, m_rd);
            end
            chk("rnd_dcnt", diag_cmd_cnt, m_cnt);

            do_pop  = 0;
            do_push = cmd_valid && (q.size() < OUTSTD);
            if (err_rd && rd_accept && q.size() > 0) begin
                if (beats == q[0].bsz) do_pop = 1;
                else beats++;
            end
            if (wr_accept && wr_valid && wr_last) wlast_seen = 1;
            if (err_wr && wr_resp_accept) do_pop = 1;
            if (do_push) begin
                if (!m_vld || diag_err_clr) begin
                    m_vld = 1; m_addr = cmd_addr; m_rd = cmd_read;
                end
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end else if (diag_err_clr) begin
                m_vld = 0;
            end
            if (do_pop) begin
                void'(q.pop_front());
                beats = 0;
                wlast_seen = 0;
            end
            if (do_push) begin
                q.push_back('{read: cmd_read, bsz: int'(cmd_bsz)});
                npush++;
            end
            tick();
        end
        cmd_valid = 0; rd_accept = 0; wr_valid = 0; wr_resp_accept = 0; diag_err_clr = 0;
        settle();
        chk("rnd_end_acc", cmd_accept, 1);
        chk("rnd_end_erd", err_rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
